registerfile_sb: RTL and testbench
==================================

// Module: registerfile_sb
// PURPOSE
//  Parametrised register file for the RV32I pipeline: N combinational read ports, one write port,
//  write-to-read bypass, hardwired-zero x0, async clear. Integrated scoreboard: per-register
//  pending-write counter gives decode a busy flag per read port and back-pressures issue.
//  Sits between decode/issue (reads, issue) and writeback (write, counter release).
// PARAMETERS
//  DATA_W   32  register width in bits
//  DEPTH    32  number of registers; ADDR_W = $clog2(DEPTH)
//  NUM_RD   2   read ports, legal 1..4
//  ZERO_REG 1   1: register 0 reads 0, ignores writes, never busy
//  BYPASS   1   1: same-cycle writeback data forwarded to matching read ports
//  CNT_W    2   pending-write counter width; max outstanding writes per reg = 2**CNT_W-1
// PORTS
//  clk          in   1               rising-edge clock
//  rst_n        in   1               async active-low reset
//  rd_addr      in   NUM_RD*ADDR_W   read addresses, port p at [p*ADDR_W +: ADDR_W]
//  rd_data      out  NUM_RD*DATA_W   read data, port p at [p*DATA_W +: DATA_W]
//  rd_busy      out  NUM_RD          port p register still has pending writes
//  iss_valid    in   1               issue of instruction writing iss_addr
//  iss_addr     in   ADDR_W          destination register of issued instruction
//  iss_ready    out  1               issue accepted this cycle when iss_valid&iss_ready
//  wb_en        in   1               writeback strobe (RegWrite)
//  wb_addr      in   ADDR_W          writeback register
//  wb_data      in   DATA_W          writeback data
//  sb_err       out  1               sticky: writeback released a register with counter 0
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers 0, all counters 0, sb_err 0; iss_ready=1,
//    rd_busy=0, rd_data=0 while in reset. Reset mid-operation discards all pending state.
//  - Write: at posedge, wb_en=1 -> reg[wb_addr]<=wb_data. ZERO_REG & wb_addr==0: no write.
//  - Read: combinational, zero latency. ZERO_REG & addr==0 -> 0. BYPASS & wb_en &
//    wb_addr==addr (addr legal nonzero) -> wb_data; else reg[addr]. BYPASS=0 -> old value
//    this cycle, new value next cycle. Addresses >= DEPTH read 0, writes to them dropped.
//  - Counter cnt[r]: inc on accepted issue to r, dec on wb_en to r with cnt[r]>0.
//    Same cycle inc+dec on same r -> unchanged. dec with cnt[r]==0 -> stays 0, sb_err<=1.
//    Register 0 (ZERO_REG) never counted; issue to it always accepted, no effect.
//  - iss_ready = !(cnt[iss_addr]==2**CNT_W-1) | (wb_en & wb_addr==iss_addr); combinational,
//    no dependency on iss_valid. Counter never wraps.
//  - rd_busy[p] = (cnt[a] - (wb_en & wb_addr==a & cnt[a]>0)) != 0, a=rd_addr[p]:
//    a writeback landing this cycle is not counted as pending (consistent with bypass).
//    With BYPASS=0, rd_busy[p] = cnt[a]!=0.
//  - Multiple outstanding writes to one register allowed up to counter max; busy clears
//    only when the last one writes back. sb_err cleared only by reset.
// STRUCTURE
//  - Package regfile_pkg: default DATA_W/DEPTH/NUM_RD/CNT_W constants, ADDR_W function,
//    RV32I zero-register index constant.
//  - Sub-module regfile_sb_cnt: one saturating up/down counter (inc, dec, cnt, full, err),
//    generated DEPTH times (DEPTH-1 when ZERO_REG). Storage and read muxes in top level.
// TESTING
//  1 Reset: write x5=0xDEADBEEF, pulse rst_n low mid-cycle -> x5 reads 0, all rd_busy 0,
//    sb_err 0, iss_ready 1 immediately (async).
//  2 Zero reg: wb x0=0xFFFFFFFF, issue x0 -> rd_addr=0 reads 0, rd_busy 0; ZERO_REG=0 build
//    -> reads 0xFFFFFFFF next cycle.
//  3 Bypass: reg x3=0x11, same cycle wb x3=0x22 with rd_addr0=rd_addr1=3 -> both ports 0x22,
//    rd_busy 0; BYPASS=0 -> 0x11 that cycle, 0x22 next.
//  4 Scoreboard: issue x7 three times (CNT_W=2) -> 4th issue iss_ready 0, rd_busy on x7 1;
//    wb x7 + issue x7 same cycle -> accepted, cnt stays 3; three wb -> busy clears on last wb.
//  5 Error: wb x9 with cnt 0 -> data 0x9 written, sb_err 1 next cycle and stays until reset.
//  6 Multiport: NUM_RD=4, random addrs vs reference model 1000 cycles with random issue/wb
//    -> rd_data/rd_busy/iss_ready match model every cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared defaults for the RV32I register file with scoreboard:
//                default geometry, counter width, zero-register index and
//                the address-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_DEPTH   = 32;
    localparam int DEF_NUM_RD  = 2;
    localparam int DEF_CNT_W   = 2;

    // RV32I x0 is the architectural zero register
    localparam int RV_ZERO_IDX = 0;

    // Address width for a given register count; a single-entry file still
    // needs one address bit so port widths never collapse to zero.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_sb_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb_cnt
//  Description : Pending-write counter for one register. Counts up on an
//                accepted issue, down on a writeback, never wraps. A
//                writeback with nothing pending raises err for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             err
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_dec_eff;
    logic             w_inc_eff;

    // A release only counts when something is outstanding; an issue only
    // counts when there is room (a same-cycle release frees a slot).
    assign w_dec_eff = dec && (r_cnt != '0);
    assign w_inc_eff = inc && ((r_cnt != C_CNT_MAX) || w_dec_eff);

    // Saturating up/down count; simultaneous effective inc and dec cancel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_inc_eff && !w_dec_eff) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (!w_inc_eff && w_dec_eff) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign cnt  = r_cnt;
    assign full = (r_cnt == C_CNT_MAX);
    assign err  = dec && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/registerfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : registerfile_sb
//  Description : Parametrised register file with NUM_RD combinational read
//                ports, one write port, optional write-to-read bypass and
//                hardwired-zero register 0. Each register carries a pending
//                write counter that drives per-port busy flags and issue
//                back-pressure; stray writebacks set a sticky error.
//  Revision    : 1.0 - initial release
// ============================================================================
module registerfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int CNT_W    = DEF_CNT_W,
    localparam int ADDR_W  = addr_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     sb_err
);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [CNT_W-1:0]  w_cnt  [DEPTH];
    logic [DEPTH-1:0]  w_full;
    logic [DEPTH-1:0]  w_err;
    logic              r_sb_err;
    logic              w_wb_live;
    logic              w_iss_ready;

    // A "live" address names a real, writable register: in range and not
    // the hardwired zero register. Everything else reads 0 and is never busy.
    function automatic logic f_live(input logic [ADDR_W-1:0] a);
        logic in_range;
        in_range = ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
        return in_range && !((ZERO_REG != 0) && (a == ADDR_W'(RV_ZERO_IDX)));
    endfunction

    assign w_wb_live = f_live(wb_addr);

    // Register storage: cleared asynchronously, written on the writeback strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && w_wb_live) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // One pending-write counter per real register; x0 gets constant ties
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        if ((ZERO_REG != 0) && (r == RV_ZERO_IDX)) begin : g_zero
            assign w_cnt[r]  = '0;
            assign w_full[r] = 1'b0;
            assign w_err[r]  = 1'b0;
        end else begin : g_cnt
            logic w_inc;
            logic w_dec;

            assign w_inc = iss_valid && w_iss_ready && (iss_addr == ADDR_W'(r));
            assign w_dec = wb_en && (wb_addr == ADDR_W'(r));

            regfile_sb_cnt #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (w_inc),
                .dec   (w_dec),
                .cnt   (w_cnt[r]),
                .full  (w_full[r]),
                .err   (w_err[r])
            );
        end
    end

    // Issue stalls only when the destination counter is saturated and no
    // writeback to that register frees a slot this cycle.
    assign w_iss_ready = !f_live(iss_addr)
                      || !w_full[iss_addr]
                      || (wb_en && (wb_addr == iss_addr));
    assign iss_ready   = w_iss_ready;

    // Sticky scoreboard error: any writeback to a register with nothing pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb_err <= 1'b0;
        end else if (|w_err) begin
            r_sb_err <= 1'b1;
        end
    end

    assign sb_err = r_sb_err;

    // Read ports: zero-latency lookup with optional same-cycle forwarding
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        logic              w_hit;
        logic [DATA_W-1:0] w_d;
        logic              w_b;

        assign w_a   = rd_addr[p*ADDR_W +: ADDR_W];
        assign w_hit = (BYPASS != 0) && wb_en && (wb_addr == w_a);

        // Forwarded writeback is treated as already retired, so busy only
        // stays up if another write is still outstanding behind it.
        always_comb begin
            w_d = '0;
            w_b = 1'b0;
            if (rst_n && f_live(w_a)) begin
                w_d = w_hit ? wb_data : r_regs[w_a];
                w_b = w_hit ? (w_cnt[w_a] > CNT_W'(1)) : (w_cnt[w_a] != '0);
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = w_d;
        assign rd_busy[p]                  = w_b;
    end

endmodule
`default_nettype wire

// File: tb/tb_registerfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_registerfile_sb
//  Description : Directed and model-checked bench for registerfile_sb. Unit A
//                is the 4-port default build; unit B shares the write/issue
//                inputs and drops zero-register and bypass behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_registerfile_sb;

    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [4*AW-1:0] rd_addr;
    logic [4*DW-1:0] rd_data_a;
    logic [3:0]      rd_busy_a;
    logic            iss_ready_a;
    logic            sb_err_a;
    logic [2*DW-1:0] rd_data_b;
    logic [1:0]      rd_busy_b;
    logic            iss_ready_b;
    logic            sb_err_b;
    logic            iss_valid;
    logic [AW-1:0]   iss_addr;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;

    int n_cmp = 0;
    int n_mis = 0;

    logic [DW-1:0]   m_regs [32];
    int              m_cnt  [32];
    int              cand   [$];
    logic [AW-1:0]   a;
    logic            hit;
    logic [DW-1:0]   exp_d;
    logic            exp_b;
    logic            exp_r;

    always #5 clk = ~clk;

    registerfile_sb #(
        .DATA_W (DW), .DEPTH (32), .NUM_RD (4),
        .ZERO_REG (1), .BYPASS (1), .CNT_W (2)
    ) u_dut_a (
        .clk (clk), .rst_n (rst_n),
        .rd_addr (rd_addr), .rd_data (rd_data_a), .rd_busy (rd_busy_a),
        .iss_valid (iss_valid), .iss_addr (iss_addr), .iss_ready (iss_ready_a),
        .wb_en (wb_en), .wb_addr (wb_addr), .wb_data (wb_data),
        .sb_err (sb_err_a)
    );

    registerfile_sb #(
        .DATA_W (DW), .DEPTH (32), .NUM_RD (2),
        .ZERO_REG (0), .BYPASS (0), .CNT_W (2)
    ) u_dut_b (
        .clk (clk), .rst_n (rst_n),
        .rd_addr (rd_addr[2*AW-1:0]), .rd_data (rd_data_b), .rd_busy (rd_busy_b),
        .iss_valid (iss_valid), .iss_addr (iss_addr), .iss_ready (iss_ready_b),
        .wb_en (wb_en), .wb_addr (wb_addr), .wb_data (wb_data),
        .sb_err (sb_err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        wb_en     = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
        rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endtask

    initial begin
        idle();
        iss_addr = '0;
        wb_addr  = '0;
        wb_data  = '0;
        set_rd(0, 0, 0, 0);

        // ---- reset state (bypass must not leak through while held) ----
        rst_n = 1'b0;
        tick();
        tick();
        set_rd(5, 0, 0, 0);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
        #1;
        check("rst_rd_data", rd_data_a[31:0], 32'h0);
        check("rst_rd_busy", 32'(rd_busy_a), 32'h0);
        check("rst_iss_ready", 32'(iss_ready_a), 32'h1);
        check("rst_sb_err", 32'(sb_err_a), 32'h0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        // ---- 1: async reset mid-cycle ----
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        tick();
        idle();
        #1;
        check("t1_x5_written", rd_data_a[31:0], 32'hDEAD_BEEF);
        iss_valid = 1'b1; iss_addr = 5'd5;
        tick();
        idle();
        #1;
        check("t1_x5_busy", 32'(rd_busy_a[0]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_rd", rd_data_a[31:0], 32'h0);
        check("t1_async_busy", 32'(rd_busy_a), 32'h0);
        check("t1_async_ready", 32'(iss_ready_a), 32'h1);
        check("t1_async_err", 32'(sb_err_a), 32'h0);
        #1 rst_n = 1'b1;
        tick();

        // ---- 2: zero register ----
        set_rd(0, 0, 0, 0);
        iss_valid = 1'b1; iss_addr = 5'd0;
        #1;
        check("t2_iss_x0_ready", 32'(iss_ready_a), 32'h1);
        tick();
        idle();
        #1;
        check("t2_x0_busy_a", 32'(rd_busy_a[0]), 32'h0);
        check("t2_x0_busy_b", 32'(rd_busy_b[0]), 32'h1);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        tick();
        idle();
        #1;
        check("t2_x0_data_a", rd_data_a[31:0], 32'h0);
        check("t2_x0_data_b", rd_data_b[31:0], 32'hFFFF_FFFF);
        check("t2_x0_busy_b_clear", 32'(rd_busy_b[0]), 32'h0);

        // ---- 3: bypass ----
        iss_valid = 1'b1; iss_addr = 5'd3;
        tick();
        tick();
        idle();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
        tick();
        set_rd(3, 3, 0, 0);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h22;
        #1;
        check("t3_byp_p0", rd_data_a[31:0], 32'h22);
        check("t3_byp_p1", rd_data_a[63:32], 32'h22);
        check("t3_byp_busy", 32'(rd_busy_a[1:0]), 32'h0);
        check("t3_nobyp_p0", rd_data_b[31:0], 32'h11);
        check("t3_nobyp_p1", rd_data_b[63:32], 32'h11);
        check("t3_nobyp_busy", 32'(rd_busy_b[0]), 32'h1);
        tick();
        idle();
        #1;
        check("t3_nobyp_next", rd_data_b[31:0], 32'h22);
        check("t3_nobyp_busy_clr", 32'(rd_busy_b[0]), 32'h0);

        // ---- 4: scoreboard saturation and release ----
        set_rd(7, 0, 0, 0);
        iss_valid = 1'b1; iss_addr = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_issue_ready", 32'(iss_ready_a), 32'h1);
            tick();
        end
        #1;
        check("t4_full_ready", 32'(iss_ready_a), 32'h0);
        check("t4_full_busy", 32'(rd_busy_a[0]), 32'h1);
        tick();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h70;
        #1;
        check("t4_wb_frees_slot", 32'(iss_ready_a), 32'h1);
        tick();
        wb_en = 1'b0;
        #1;
        check("t4_still_full", 32'(iss_ready_a), 32'h0);
        iss_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h71 + 32'(i);
            #1;
            check("t4_drain_busy", 32'(rd_busy_a[0]), (i < 2) ? 32'h1 : 32'h0);
            tick();
        end
        idle();
        #1;
        check("t4_drained_busy", 32'(rd_busy_a[0]), 32'h0);
        check("t4_drained_data", rd_data_a[31:0], 32'h73);
        check("t4_drained_ready", 32'(iss_ready_a), 32'h1);
        check("t4_no_err", 32'(sb_err_a), 32'h0);

        // ---- 5: stray writeback error ----
        set_rd(9, 0, 0, 0);
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h9;
        #1;
        check("t5_err_not_yet", 32'(sb_err_a), 32'h0);
        tick();
        idle();
        #1;
        check("t5_x9_data", rd_data_a[31:0], 32'h9);
        check("t5_err_set", 32'(sb_err_a), 32'h1);
        check("t5_x9_not_busy", 32'(rd_busy_a[0]), 32'h0);
        tick();
        tick();
        check("t5_err_sticky", 32'(sb_err_a), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_err_reset", 32'(sb_err_a), 32'h0);
        rst_n = 1'b1;
        tick();

        // ---- 6: four-port random traffic against a reference model ----
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_cnt[r]  = 0;
        end
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int p = 0; p < 4; p++) begin
                rd_addr[p*AW +: AW] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7))
                                                                  : AW'($urandom_range(0, 31));
            end
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_addr  = AW'($urandom_range(0, 7));
            cand.delete();
            for (int r = 1; r < 32; r++) begin
                if (m_cnt[r] > 0) cand.push_back(r);
            end
            wb_en   = 1'b0;
            wb_addr = '0;
            wb_data = $urandom;
            if ($urandom_range(0, 15) == 0) begin
                wb_en = 1'b1;
            end else if ((cand.size() > 0) && ($urandom_range(0, 2) != 0)) begin
                wb_en   = 1'b1;
                wb_addr = AW'(cand[$urandom_range(0, cand.size() - 1)]);
            end
            #1;
            for (int p = 0; p < 4; p++) begin
                a     = rd_addr[p*AW +: AW];
                hit   = wb_en && (wb_addr == a);
                exp_d = (a == 0) ? 32'h0 : (hit ? wb_data : m_regs[a]);
                exp_b = (a == 0) ? 1'b0
                      : ((m_cnt[a] - ((hit && m_cnt[a] > 0) ? 1 : 0)) != 0);
                check("t6_rd_data", rd_data_a[p*DW +: DW], exp_d);
                check("t6_rd_busy", 32'(rd_busy_a[p]), 32'(exp_b));
            end
            exp_r = (iss_addr == 0) || (m_cnt[iss_addr] != 3) || (wb_en && (wb_addr == iss_addr));
            check("t6_iss_ready", 32'(iss_ready_a), 32'(exp_r));
            if (wb_en && (wb_addr != 0)) begin
                m_regs[wb_addr] = wb_data;
                if (m_cnt[wb_addr] > 0) m_cnt[wb_addr] = m_cnt[wb_addr] - 1;
            end
            if (iss_valid && exp_r && (iss_addr != 0)) begin
                m_cnt[iss_addr] = m_cnt[iss_addr] + 1;
            end
            tick();
        end
        idle();
        #1;
        check("t6_no_err", 32'(sb_err_a), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
